// File: rtl/midi_seq_parser_if.sv
// Byte-in / classified-byte-out bundle between the UART receiver,
// midi_seq_parser and the downstream sysex and note/controller handlers.
interface midi_seq_parser_if;
    logic       byte_ready;
    logic [7:0] midi_rx_byte;
    logic       trig_seq_f;
    logic [7:0] seq_databyte;
    logic [7:0] midi_bytes;
    logic       is_st_sysex;
    logic       is_st_note_on;
    logic       is_st_note_off;
    logic       is_st_ctrl;
    logic       is_st_pitch;
    logic       is_st_prog;
    logic [3:0] midi_ch_in;
    logic       msg_done;
    logic       rt_byte_f;
    logic [7:0] rt_byte;
    logic       sysex_abort;
    logic       overrun;

    modport master (
        output byte_ready, midi_rx_byte,
        input  trig_seq_f, seq_databyte, midi_bytes, is_st_sysex,
               is_st_note_on, is_st_note_off, is_st_ctrl, is_st_pitch,
               is_st_prog, midi_ch_in, msg_done, rt_byte_f, rt_byte,
               sysex_abort, overrun
    );

    modport slave (
        input  byte_ready, midi_rx_byte,
        output trig_seq_f, seq_databyte, midi_bytes, is_st_sysex,
               is_st_note_on, is_st_note_off, is_st_ctrl, is_st_pitch,
               is_st_prog, midi_ch_in, msg_done, rt_byte_f, rt_byte,
               sysex_abort, overrun
    );
endinterface

// File: rtl/midi_seq_parser.sv
// MIDI byte classifier: tracks (running) status, counts byte position within
// each message and presents one registered strobe per byte downstream.
module midi_seq_parser #(
    parameter logic [7:0] SAT_MAX        = 8'd255,
    parameter bit         RUNNING_STATUS = 1'b1
) (
    input logic               reg_clk,
    input logic               reset_reg_N,
    midi_seq_parser_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, CHAN, SYSC, SYSEX, ABORT_EMIT} state_t;

    state_t     state_q, nxt_state;
    logic [7:0] pend_q, pend_d;
    logic [1:0] len_q, len_d;

    logic       trig_q, trig_d;
    logic [7:0] db_q, db_d;
    logic [7:0] mb_q, mb_d;
    logic       sx_q, sx_d;
    logic [4:0] flags_q, flags_d;   // {note_on, note_off, ctrl, pitch, prog}
    logic [3:0] ch_q, ch_d;
    logic       done_q, done_d;
    logic       rtf_q, rtf_d;
    logic [7:0] rt_q, rt_d;
    logic       abort_q, abort_d;
    logic       ovr_q, ovr_d;

    logic       is_rt;
    logic       in_v;
    logic [7:0] in_b;
    logic [7:0] sat_inc;
    logic [7:0] chan_nxt;
    logic [7:0] sysc_nxt;

    assign sat_inc  = (mb_q >= SAT_MAX) ? SAT_MAX : mb_q + 8'd1;
    assign chan_nxt = (mb_q >= {6'd0, len_q}) ? 8'd1 : mb_q + 8'd1;
    assign sysc_nxt = mb_q + 8'd1;

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) state_q <= IDLE;
        else              state_q <= nxt_state;
    end

    always_comb begin
        nxt_state = state_q;
        pend_d    = pend_q;
        len_d     = len_q;
        trig_d    = 1'b0;
        db_d      = db_q;
        mb_d      = mb_q;
        sx_d      = sx_q & ~(trig_q & done_q);
        flags_d   = flags_q;
        ch_d      = ch_q;
        done_d    = 1'b0;
        rtf_d     = 1'b0;
        rt_d      = rt_q;
        abort_d   = 1'b0;
        ovr_d     = 1'b0;

        // Realtime bytes bypass the parser entirely, even while the aborted
        // status byte is being replayed from the pending slot.
        is_rt = bus.byte_ready && (bus.midi_rx_byte >= 8'hF8);
        if (state_q == ABORT_EMIT) begin
            in_v = 1'b1;
            in_b = pend_q;
            ovr_d = bus.byte_ready && !is_rt;
        end else begin
            in_v = bus.byte_ready && !is_rt;
            in_b = bus.midi_rx_byte;
        end

        if (is_rt) begin
            rtf_d = 1'b1;
            rt_d  = bus.midi_rx_byte;
        end

        if (in_v) begin
            if (!in_b[7]) begin
                case (state_q)
                    CHAN: begin
                        trig_d = 1'b1;
                        db_d   = in_b;
                        mb_d   = chan_nxt;
                        done_d = (chan_nxt == {6'd0, len_q});
                        if (done_d && !RUNNING_STATUS) nxt_state = IDLE;
                    end
                    SYSC: begin
                        trig_d = 1'b1;
                        db_d   = in_b;
                        mb_d   = sysc_nxt;
                        done_d = (sysc_nxt == {6'd0, len_q});
                        if (done_d) nxt_state = IDLE;
                    end
                    SYSEX: begin
                        trig_d = 1'b1;
                        db_d   = in_b;
                        mb_d   = sat_inc;
                        sx_d   = 1'b1;
                    end
                    default: ;
                endcase
            end else if (in_b == 8'hF7) begin
                if (state_q == SYSEX) begin
                    trig_d    = 1'b1;
                    db_d      = 8'hF7;
                    mb_d      = sat_inc;
                    sx_d      = 1'b1;
                    done_d    = 1'b1;
                    nxt_state = IDLE;
                end
            end else if (state_q == SYSEX) begin
                trig_d    = 1'b1;
                db_d      = 8'hF7;
                mb_d      = sat_inc;
                sx_d      = 1'b1;
                done_d    = 1'b1;
                abort_d   = 1'b1;
                pend_d    = in_b;
                nxt_state = ABORT_EMIT;
            end else begin
                trig_d  = 1'b1;
                db_d    = in_b;
                mb_d    = 8'd0;
                sx_d    = 1'b0;
                flags_d = 5'b00000;
                if (in_b < 8'hF0) begin
                    ch_d = in_b[3:0];
                    case (in_b[7:4])
                        4'h9:    flags_d = 5'b10000;
                        4'h8:    flags_d = 5'b01000;
                        4'hB:    flags_d = 5'b00100;
                        4'hE:    flags_d = 5'b00010;
                        4'hC:    flags_d = 5'b00001;
                        default: flags_d = 5'b00000;
                    endcase
                    len_d     = (in_b[7:4] == 4'hC || in_b[7:4] == 4'hD) ? 2'd1 : 2'd2;
                    nxt_state = CHAN;
                end else begin
                    case (in_b[3:0])
                        4'h0: begin
                            sx_d      = 1'b1;
                            nxt_state = SYSEX;
                        end
                        4'h1, 4'h3: begin
                            len_d     = 2'd1;
                            nxt_state = SYSC;
                        end
                        4'h2: begin
                            len_d     = 2'd2;
                            nxt_state = SYSC;
                        end
                        default: begin
                            len_d     = 2'd0;
                            done_d    = 1'b1;
                            nxt_state = IDLE;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            pend_q  <= '0;
            len_q   <= '0;
            trig_q  <= 1'b0;
            db_q    <= '0;
            mb_q    <= '0;
            sx_q    <= 1'b0;
            flags_q <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
            rtf_q   <= 1'b0;
            rt_q    <= '0;
            abort_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            len_q   <= len_d;
            trig_q  <= trig_d;
            db_q    <= db_d;
            mb_q    <= mb_d;
            sx_q    <= sx_d;
            flags_q <= flags_d;
            ch_q    <= ch_d;
            done_q  <= done_d;
            rtf_q   <= rtf_d;
            rt_q    <= rt_d;
            abort_q <= abort_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.trig_seq_f     = trig_q;
    assign bus.seq_databyte   = db_q;
    assign bus.midi_bytes     = mb_q;
    assign bus.is_st_sysex    = sx_q;
    assign bus.is_st_note_on  = flags_q[4];
    assign bus.is_st_note_off = flags_q[3];
    assign bus.is_st_ctrl     = flags_q[2];
    assign bus.is_st_pitch    = flags_q[1];
    assign bus.is_st_prog     = flags_q[0];
    assign bus.midi_ch_in     = ch_q;
    assign bus.msg_done       = done_q;
    assign bus.rt_byte_f      = rtf_q;
    assign bus.rt_byte        = rt_q;
    assign bus.sysex_abort    = abort_q;
    assign bus.overrun        = ovr_q;

endmodule

// File: tb/tb_midi_seq_parser.sv
// Directed bench for midi_seq_parser: sysex, running status, abort, realtime,
// saturation, system common, overrun and mid-message reset.
module tb_midi_seq_parser;

    logic reg_clk;
    logic reset_reg_N;
    int   n_pass  = 0;
    int   n_total = 0;

    midi_seq_parser_if bus();

    midi_seq_parser #(.SAT_MAX(8'd255), .RUNNING_STATUS(1'b1)) dut (
        .reg_clk     (reg_clk),
        .reset_reg_N (reset_reg_N),
        .bus         (bus)
    );

    initial reg_clk = 1'b0;
    always #5 reg_clk = ~reg_clk;

    logic [38:0] all_out;
    logic [4:0]  flags;
    assign flags   = {bus.is_st_note_on, bus.is_st_note_off, bus.is_st_ctrl,
                      bus.is_st_pitch, bus.is_st_prog};
    assign all_out = {bus.trig_seq_f, bus.seq_databyte, bus.midi_bytes, bus.is_st_sysex,
                      flags, bus.midi_ch_in, bus.msg_done, bus.rt_byte_f, bus.rt_byte,
                      bus.sysex_abort, bus.overrun};

    // Called at a falling edge; returns at the next falling edge, where the
    // registered result for the byte is visible.
    task automatic drive(input logic [7:0] b);
        bus.byte_ready   = 1'b1;
        bus.midi_rx_byte = b;
        @(negedge reg_clk);
        bus.byte_ready   = 1'b0;
    endtask

    task automatic test_reset();
        reset_reg_N      = 1'b0;
        bus.byte_ready   = 1'b0;
        bus.midi_rx_byte = 8'h00;
        #12;
        n_total++;
        if (all_out !== 39'd0) $display("FAIL reset_outputs: got %h want 0", all_out);
        else n_pass++;
        @(negedge reg_clk);
        reset_reg_N = 1'b1;
        @(negedge reg_clk);
    endtask

    task automatic test_sysex();
        logic [7:0] seq [6] = '{8'hF0, 8'h7D, 8'h71, 8'h01, 8'h02, 8'hF7};
        for (int i = 0; i < 6; i++) begin
            drive(seq[i]);
            n_total++;
            if (bus.trig_seq_f !== 1'b1 || bus.seq_databyte !== seq[i] ||
                bus.midi_bytes !== 8'(i) || bus.is_st_sysex !== 1'b1 ||
                bus.msg_done !== (i == 5) || flags !== 5'b0)
                $display("FAIL sysex_byte%0d: trig=%b db=%h mb=%0d sx=%b done=%b fl=%b want db=%h mb=%0d done=%b",
                         i, bus.trig_seq_f, bus.seq_databyte, bus.midi_bytes, bus.is_st_sysex,
                         bus.msg_done, flags, seq[i], i, (i == 5));
            else n_pass++;
        end
        @(negedge reg_clk);
        n_total++;
        if (bus.is_st_sysex !== 1'b0 || bus.trig_seq_f !== 1'b0)
            $display("FAIL sysex_clear: sx=%b trig=%b want 0 0", bus.is_st_sysex, bus.trig_seq_f);
        else n_pass++;
    endtask

    task automatic test_running_status();
        logic [7:0] seq  [5] = '{8'h93, 8'h3C, 8'h64, 8'h3E, 8'h50};
        logic [7:0] idx  [5] = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2};
        logic       done [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(seq[i]);
            n_total++;
            if (bus.trig_seq_f !== 1'b1 || bus.seq_databyte !== seq[i] ||
                bus.midi_bytes !== idx[i] || bus.msg_done !== done[i] ||
                flags !== 5'b10000 || bus.midi_ch_in !== 4'd3 || bus.is_st_sysex !== 1'b0)
                $display("FAIL running_byte%0d: trig=%b db=%h mb=%0d done=%b fl=%b ch=%0d want mb=%0d done=%b fl=10000 ch=3",
                         i, bus.trig_seq_f, bus.seq_databyte, bus.midi_bytes, bus.msg_done,
                         flags, bus.midi_ch_in, idx[i], done[i]);
            else n_pass++;
        end
        @(negedge reg_clk);
    endtask

    task automatic test_abort();
        drive(8'hF0);
        drive(8'h7D);
        drive(8'h10);
        drive(8'h93);
        n_total++;
        if (bus.trig_seq_f !== 1'b1 || bus.seq_databyte !== 8'hF7 || bus.midi_bytes !== 8'd3 ||
            bus.is_st_sysex !== 1'b1 || bus.msg_done !== 1'b1 || bus.sysex_abort !== 1'b1)
            $display("FAIL abort_synth: trig=%b db=%h mb=%0d sx=%b done=%b abort=%b want 1 f7 3 1 1 1",
                     bus.trig_seq_f, bus.seq_databyte, bus.midi_bytes, bus.is_st_sysex,
                     bus.msg_done, bus.sysex_abort);
        else n_pass++;
        @(negedge reg_clk);
        n_total++;
        if (bus.trig_seq_f !== 1'b1 || bus.seq_databyte !== 8'h93 || bus.midi_bytes !== 8'd0 ||
            bus.is_st_sysex !== 1'b0 || flags !== 5'b10000 || bus.sysex_abort !== 1'b0 ||
            bus.msg_done !== 1'b0 || bus.midi_ch_in !== 4'd3)
            $display("FAIL abort_pending: trig=%b db=%h mb=%0d sx=%b fl=%b abort=%b done=%b want 1 93 0 0 10000 0 0",
                     bus.trig_seq_f, bus.seq_databyte, bus.midi_bytes, bus.is_st_sysex,
                     flags, bus.sysex_abort, bus.msg_done);
        else n_pass++;
        @(negedge reg_clk);
    endtask

    task automatic test_overrun();
        drive(8'hF0);
        drive(8'h11);
        drive(8'h90);
        drive(8'h55);
        n_total++;
        if (bus.overrun !== 1'b1 || bus.trig_seq_f !== 1'b1 || bus.seq_databyte !== 8'h90 ||
            bus.midi_bytes !== 8'd0)
            $display("FAIL overrun_pulse: ovr=%b trig=%b db=%h mb=%0d want 1 1 90 0",
                     bus.overrun, bus.trig_seq_f, bus.seq_databyte, bus.midi_bytes);
        else n_pass++;
        drive(8'h66);
        n_total++;
        if (bus.trig_seq_f !== 1'b1 || bus.seq_databyte !== 8'h66 || bus.midi_bytes !== 8'd1 ||
            bus.overrun !== 1'b0 || flags !== 5'b10000 || bus.midi_ch_in !== 4'd0)
            $display("FAIL overrun_dropped: trig=%b db=%h mb=%0d ovr=%b fl=%b ch=%0d want 1 66 1 0 10000 0",
                     bus.trig_seq_f, bus.seq_databyte, bus.midi_bytes, bus.overrun, flags, bus.midi_ch_in);
        else n_pass++;
        @(negedge reg_clk);
    endtask

    task automatic test_realtime();
        drive(8'hB0);
        drive(8'h07);
        drive(8'hF8);
        n_total++;
        if (bus.rt_byte_f !== 1'b1 || bus.rt_byte !== 8'hF8 || bus.trig_seq_f !== 1'b0 ||
            bus.midi_bytes !== 8'd1 || flags !== 5'b00100)
            $display("FAIL rt_pulse: rtf=%b rt=%h trig=%b mb=%0d fl=%b want 1 f8 0 1 00100",
                     bus.rt_byte_f, bus.rt_byte, bus.trig_seq_f, bus.midi_bytes, flags);
        else n_pass++;
        drive(8'h40);
        n_total++;
        if (bus.trig_seq_f !== 1'b1 || bus.seq_databyte !== 8'h40 || bus.midi_bytes !== 8'd2 ||
            bus.msg_done !== 1'b1 || flags !== 5'b00100 || bus.rt_byte_f !== 1'b0 ||
            bus.rt_byte !== 8'hF8)
            $display("FAIL rt_resume: trig=%b db=%h mb=%0d done=%b fl=%b rtf=%b rt=%h want 1 40 2 1 00100 0 f8",
                     bus.trig_seq_f, bus.seq_databyte, bus.midi_bytes, bus.msg_done, flags,
                     bus.rt_byte_f, bus.rt_byte);
        else n_pass++;
        @(negedge reg_clk);
    endtask

    task automatic test_saturation();
        logic [7:0] exp_mb;
        drive(8'hF0);
        for (int i = 1; i <= 300; i++) begin
            drive(8'(i & 8'h7F));
            exp_mb = (i > 255) ? 8'd255 : 8'(i);
            n_total++;
            if (bus.trig_seq_f !== 1'b1 || bus.midi_bytes !== exp_mb || bus.msg_done !== 1'b0)
                $display("FAIL sat_data%0d: trig=%b mb=%0d done=%b want 1 %0d 0",
                         i, bus.trig_seq_f, bus.midi_bytes, bus.msg_done, exp_mb);
            else n_pass++;
        end
        drive(8'hF7);
        n_total++;
        if (bus.trig_seq_f !== 1'b1 || bus.seq_databyte !== 8'hF7 || bus.midi_bytes !== 8'd255 ||
            bus.msg_done !== 1'b1 || bus.is_st_sysex !== 1'b1)
            $display("FAIL sat_end: trig=%b db=%h mb=%0d done=%b sx=%b want 1 f7 255 1 1",
                     bus.trig_seq_f, bus.seq_databyte, bus.midi_bytes, bus.msg_done, bus.is_st_sysex);
        else n_pass++;
        @(negedge reg_clk);
    endtask

    task automatic test_syscommon();
        logic [7:0] seq  [3] = '{8'hF2, 8'h01, 8'h02};
        for (int i = 0; i < 3; i++) begin
            drive(seq[i]);
            n_total++;
            if (bus.trig_seq_f !== 1'b1 || bus.seq_databyte !== seq[i] ||
                bus.midi_bytes !== 8'(i) || bus.msg_done !== (i == 2) || flags !== 5'b0 ||
                bus.is_st_sysex !== 1'b0)
                $display("FAIL syscom_byte%0d: trig=%b db=%h mb=%0d done=%b fl=%b want mb=%0d done=%b fl=0",
                         i, bus.trig_seq_f, bus.seq_databyte, bus.midi_bytes, bus.msg_done,
                         flags, i, (i == 2));
            else n_pass++;
        end
        drive(8'h05);
        n_total++;
        if (bus.trig_seq_f !== 1'b0) $display("FAIL syscom_no_running: trig=%b want 0", bus.trig_seq_f);
        else n_pass++;
        drive(8'hF6);
        n_total++;
        if (bus.trig_seq_f !== 1'b1 || bus.midi_bytes !== 8'd0 || bus.msg_done !== 1'b1)
            $display("FAIL syscom_f6: trig=%b mb=%0d done=%b want 1 0 1",
                     bus.trig_seq_f, bus.midi_bytes, bus.msg_done);
        else n_pass++;
        drive(8'hF7);
        n_total++;
        if (bus.trig_seq_f !== 1'b0 || bus.is_st_sysex !== 1'b0)
            $display("FAIL stray_f7: trig=%b sx=%b want 0 0", bus.trig_seq_f, bus.is_st_sysex);
        else n_pass++;
        @(negedge reg_clk);
    endtask

    task automatic test_reset_mid();
        drive(8'h90);
        drive(8'h3C);
        #2 reset_reg_N = 1'b0;
        #1;
        n_total++;
        if (all_out !== 39'd0) $display("FAIL reset_mid_outputs: got %h want 0", all_out);
        else n_pass++;
        @(negedge reg_clk);
        reset_reg_N = 1'b1;
        @(negedge reg_clk);
        drive(8'h40);
        n_total++;
        if (bus.trig_seq_f !== 1'b0 || all_out !== 39'd0)
            $display("FAIL reset_mid_drop: trig=%b out=%h want 0 0", bus.trig_seq_f, all_out);
        else n_pass++;
        @(negedge reg_clk);
    endtask

    initial begin
        test_reset();
        test_sysex();
        test_running_status();
        test_abort();
        test_overrun();
        test_realtime();
        test_saturation();
        test_syscommon();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
